pi_leaf_interface: RTL and testbench

Leaf-side endpoint of the BFT network: it converts a processing element's valid/ready streams into network packets and back. On transmit it buffers PE requests in a TX FIFO, formats them as packets and drives them into the leaf port of the lowest-level switch. On receive it captures packets arriving from that switch into an RX FIFO for the PE. The network has no backpressure, so a packet the leaf cannot accept is bounced straight back into the network.

---
 rtl/pi_leaf_interface.sv | 175 +++++++++++++++++
 tb/tb_pi_leaf_interface.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_leaf_interface.sv
// pi_leaf_interface
//   Leaf-side endpoint of a BFT network. PE transmit requests are buffered
//   in a TX FIFO and driven into the lowest-level switch as packets.
//   Packets from the switch that are addressed to this leaf go into an
//   RX FIFO for the PE. The network has no backpressure, so any packet
//   that cannot be accepted (misrouted, or RX FIFO full) is bounced
//   straight back onto bus_o. A bounce always has priority over TX traffic.
//
//   Packet layout: [p_sz-1] valid, [p_sz-2:payload_sz] dest, [payload_sz-1:0] payload.
//
//   Optional feature macro: PI_LEAF_STATS_EN adds a saturating 16-bit
//   bounce counter on output bounce_cnt.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   bus_i       packet from the switch leaf output
//   bus_o       registered packet to the switch leaf input
//   tx_valid    PE transmit request valid
//   tx_ready    TX FIFO not full (from registered occupancy)
//   tx_addr     destination leaf address
//   tx_data     payload to send
//   rx_valid    RX FIFO non-empty
//   rx_ready    PE consumes the RX head
//   rx_data     RX head payload, first-word fall-through, zero when empty
//   bounce_cnt  bounced-packet count (PI_LEAF_STATS_EN only)
module pi_leaf_interface #(
    parameter int num_leaves = 2,
    parameter int payload_sz = 1,
    parameter int addr       = 0,
    parameter int p_sz       = 1 + $clog2(num_leaves) + payload_sz,
    parameter int fifo_depth = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [p_sz-1:0]               bus_i,
    output logic [p_sz-1:0]               bus_o,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [$clog2(num_leaves)-1:0] tx_addr,
    input  logic [payload_sz-1:0]         tx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [payload_sz-1:0]         rx_data
`ifdef PI_LEAF_STATS_EN
    ,
    output logic [15:0]                   bounce_cnt
`endif
);

    localparam int A  = $clog2(num_leaves);
    localparam int PW = $clog2(fifo_depth);
    localparam int EW = A + payload_sz;

    localparam logic [PW:0]   CNT_FULL = (PW+1)'(fifo_depth);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [A-1:0]  MY_ADDR  = A'(addr);

    // TX FIFO state
    logic [EW-1:0]   tx_mem_q [fifo_depth];
    logic [PW-1:0]   tx_wr_q, tx_wr_d;
    logic [PW-1:0]   tx_rd_q, tx_rd_d;
    logic [PW:0]     tx_cnt_q, tx_cnt_d;

    // RX FIFO state
    logic [payload_sz-1:0] rx_mem_q [fifo_depth];
    logic [PW-1:0]   rx_wr_q, rx_wr_d;
    logic [PW-1:0]   rx_rd_q, rx_rd_d;
    logic [PW:0]     rx_cnt_q, rx_cnt_d;

    logic [p_sz-1:0] bus_q, bus_d;

    logic            in_vld;
    logic [A-1:0]    in_dest;
    logic            rx_full;
    logic            deliver;
    logic            bounce;
    logic            tx_push;
    logic            tx_pop;
    logic            rx_push;
    logic            rx_pop;

    assign in_vld  = bus_i[p_sz-1];
    assign in_dest = bus_i[p_sz-2:payload_sz];

    // Full checks use registered occupancy only: a same-cycle pop never
    // frees a slot for a same-cycle write.
    assign rx_full  = (rx_cnt_q == CNT_FULL);
    assign tx_ready = (tx_cnt_q != CNT_FULL);

    assign deliver = in_vld && (in_dest == MY_ADDR) && !rx_full;
    assign bounce  = in_vld && !deliver;

    assign tx_push = tx_valid && tx_ready;
    // A bounce owns the output slot, so TX waits while bounces persist.
    assign tx_pop  = !bounce && (tx_cnt_q != '0);

    assign rx_push  = deliver;
    assign rx_valid = (rx_cnt_q != '0);
    assign rx_pop   = rx_valid && rx_ready;
    // Gate the head so rx_data reads zero whenever the FIFO is empty.
    assign rx_data  = rx_valid ? rx_mem_q[rx_rd_q] : '0;

    assign bus_o = bus_q;

    always_comb begin
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_push) tx_wr_d = tx_wr_q + PTR_ONE;
        if (tx_pop)  tx_rd_d = tx_rd_q + PTR_ONE;
        if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CNT_ONE;
        else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CNT_ONE;
    end

    always_comb begin
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_push) rx_wr_d = rx_wr_q + PTR_ONE;
        if (rx_pop)  rx_rd_d = rx_rd_q + PTR_ONE;
        if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CNT_ONE;
        else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CNT_ONE;
    end

    always_comb begin
        bus_d = '0;
        if (bounce)      bus_d = bus_i;
        else if (tx_pop) bus_d = {1'b1, tx_mem_q[tx_rd_q]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            bus_q    <= '0;
        end else begin
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_cnt_q <= rx_cnt_d;
            bus_q    <= bus_d;
        end
    end

    // Storage arrays carry no reset; occupancy counters define validity.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= {tx_addr, tx_data};
        if (rx_push) rx_mem_q[rx_wr_q] <= bus_i[payload_sz-1:0];
    end

`ifdef PI_LEAF_STATS_EN
    logic [15:0] bounce_cnt_q, bounce_cnt_d;

    always_comb begin
        bounce_cnt_d = bounce_cnt_q;
        if (bounce && (bounce_cnt_q != 16'hFFFF)) bounce_cnt_d = bounce_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bounce_cnt_q <= '0;
        else       bounce_cnt_q <= bounce_cnt_d;
    end

    assign bounce_cnt = bounce_cnt_q;
`endif

endmodule

// File: tb/tb_pi_leaf_interface.sv
// Testbench for pi_leaf_interface: num_leaves=4, payload_sz=8, addr=1,
// fifo_depth=4 (packet width 11). Inputs are driven 1 time unit after each
// rising edge and outputs are sampled at that same point.
module tb_pi_leaf_interface;

    localparam int NL = 4;
    localparam int PS = 8;
    localparam int AD = 1;
    localparam int PZ = 11;
    localparam int FD = 4;

    logic          clk;
    logic          reset;
    logic [PZ-1:0] bus_i;
    logic [PZ-1:0] bus_o;
    logic          tx_valid;
    logic          tx_ready;
    logic [1:0]    tx_addr;
    logic [PS-1:0] tx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [PS-1:0] rx_data;
`ifdef PI_LEAF_STATS_EN
    logic [15:0]   bounce_cnt;
`endif

    int total;
    int bad;

    pi_leaf_interface #(
        .num_leaves(NL),
        .payload_sz(PS),
        .addr(AD),
        .p_sz(PZ),
        .fifo_depth(FD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus_i(bus_i),
        .bus_o(bus_o),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_addr(tx_addr),
        .tx_data(tx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_data(rx_data)
`ifdef PI_LEAF_STATS_EN
        ,
        .bounce_cnt(bounce_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [PZ-1:0] pkt(input logic [1:0] d, input logic [7:0] p);
        return {1'b1, d, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++; if (bus_o !== '0) begin bad++; $display("FAIL reset_bus_o got=%h want=%h", bus_o, 11'h0); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got=%b want=1", tx_ready); end
`ifdef PI_LEAF_STATS_EN
        total++; if (bounce_cnt !== 16'd0) begin bad++; $display("FAIL reset_bounce_cnt got=%0d want=0", bounce_cnt); end
`endif
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_tx();
        tx_valid = 1'b1; tx_addr = 2'd2; tx_data = 8'hA5;
        tick();
        tx_valid = 1'b0;
        total++; if (bus_o !== '0) begin bad++; $display("FAIL tx_first_cycle got=%h want=%h", bus_o, 11'h0); end
        tick();
        total++; if (bus_o !== 11'h6A5) begin bad++; $display("FAIL tx_packet got=%h want=%h", bus_o, 11'h6A5); end
        tick();
        total++; if (bus_o !== '0) begin bad++; $display("FAIL tx_after got=%h want=%h", bus_o, 11'h0); end
    endtask

    task automatic test_basic_rx();
        rx_ready = 1'b0;
        bus_i = pkt(2'd1, 8'h3C);
        tick();
        bus_i = '0;
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL rx_valid got=%b want=1", rx_valid); end
        total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL rx_data got=%h want=3c", rx_data); end
        total++; if (bus_o !== '0) begin bad++; $display("FAIL rx_no_bounce got=%h want=%h", bus_o, 11'h0); end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rx_pop_valid got=%b want=0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rx_pop_data got=%h want=00", rx_data); end
    endtask

    task automatic test_rx_full_bounce();
        logic [PZ-1:0] p;
        rx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            p = pkt(2'd1, 8'(8'h10 + i));
            bus_i = p;
            tick();
            if (i < 4) begin
                total++; if (bus_o !== '0) begin bad++; $display("FAIL rxfull_queue%0d got=%h want=%h", i, bus_o, 11'h0); end
            end else begin
                total++; if (bus_o !== p) begin bad++; $display("FAIL rxfull_bounce got=%h want=%h", bus_o, p); end
            end
        end
        bus_i = '0;
`ifdef PI_LEAF_STATS_EN
        total++; if (bounce_cnt !== 16'd1) begin bad++; $display("FAIL rxfull_bounce_cnt got=%0d want=1", bounce_cnt); end
`endif
        tick();
        total++; if (bus_o !== '0) begin bad++; $display("FAIL rxfull_idle got=%h want=%h", bus_o, 11'h0); end
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (rx_data !== 8'(8'h10 + i)) begin bad++; $display("FAIL rxfull_drain%0d got=%h want=%h", i, rx_data, 8'(8'h10 + i)); end
            tick();
        end
        rx_ready = 1'b0;
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rxfull_empty got=%b want=0", rx_valid); end
    endtask

    task automatic test_misroute_contention();
        logic [PZ-1:0] ma, mb, mc, ta, tb;
        ma = pkt(2'd3, 8'h71);
        mb = pkt(2'd0, 8'h72);
        mc = pkt(2'd3, 8'h73);
        ta = pkt(2'd0, 8'h11);
        tb = pkt(2'd2, 8'h22);
        tx_valid = 1'b1; tx_addr = 2'd0; tx_data = 8'h11; bus_i = ma;
        tick();
        total++; if (bus_o !== ma) begin bad++; $display("FAIL mis_bounce_a got=%h want=%h", bus_o, ma); end
        tx_addr = 2'd2; tx_data = 8'h22; bus_i = mb;
        tick();
        total++; if (bus_o !== mb) begin bad++; $display("FAIL mis_bounce_b got=%h want=%h", bus_o, mb); end
        tx_valid = 1'b0; bus_i = mc;
        tick();
        bus_i = '0;
        total++; if (bus_o !== mc) begin bad++; $display("FAIL mis_bounce_c got=%h want=%h", bus_o, mc); end
        tick();
        total++; if (bus_o !== ta) begin bad++; $display("FAIL mis_tx_a got=%h want=%h", bus_o, ta); end
        tick();
        total++; if (bus_o !== tb) begin bad++; $display("FAIL mis_tx_b got=%h want=%h", bus_o, tb); end
        tick();
        total++; if (bus_o !== '0) begin bad++; $display("FAIL mis_idle got=%h want=%h", bus_o, 11'h0); end
`ifdef PI_LEAF_STATS_EN
        total++; if (bounce_cnt !== 16'd4) begin bad++; $display("FAIL mis_bounce_cnt got=%0d want=4", bounce_cnt); end
`endif
    endtask

    task automatic test_tx_full();
        logic [PZ-1:0] x;
        logic [PZ-1:0] e;
        // Misrouted traffic holds the TX FIFO so it can fill up.
        for (int i = 0; i < 4; i++) begin
            x = pkt(2'd0, 8'(8'h80 + i));
            tx_valid = 1'b1; tx_addr = 2'd3; tx_data = 8'(8'h50 + i); bus_i = x;
            tick();
            total++; if (bus_o !== x) begin bad++; $display("FAIL txfull_bounce%0d got=%h want=%h", i, bus_o, x); end
            total++; if (tx_ready !== (i < 3)) begin bad++; $display("FAIL txfull_ready%0d got=%b want=%b", i, tx_ready, (i < 3)); end
        end
        x = pkt(2'd2, 8'h84);
        tx_data = 8'h54; bus_i = x;
        tick();
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL txfull_hold got=%b want=0", tx_ready); end
        total++; if (bus_o !== x) begin bad++; $display("FAIL txfull_bounce4 got=%h want=%h", bus_o, x); end
        bus_i = '0;
        tick();
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL txfull_release got=%b want=1", tx_ready); end
        total++; if (bus_o !== pkt(2'd3, 8'h50)) begin bad++; $display("FAIL txfull_out0 got=%h want=%h", bus_o, pkt(2'd3, 8'h50)); end
        tick();
        tx_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            e = pkt(2'd3, 8'(8'h50 + i));
            total++; if (bus_o !== e) begin bad++; $display("FAIL txfull_out%0d got=%h want=%h", i, bus_o, e); end
            tick();
        end
        total++; if (bus_o !== '0) begin bad++; $display("FAIL txfull_idle got=%h want=%h", bus_o, 11'h0); end
`ifdef PI_LEAF_STATS_EN
        total++; if (bounce_cnt !== 16'd9) begin bad++; $display("FAIL txfull_bounce_cnt got=%0d want=9", bounce_cnt); end
`endif
        // Back-to-back stream across the pointer wrap.
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                tx_valid = 1'b1; tx_addr = 2'(i); tx_data = 8'(8'hC0 + i);
            end else begin
                tx_valid = 1'b0;
            end
            tick();
            e = (i == 0) ? '0 : pkt(2'(i - 1), 8'(8'hC0 + i - 1));
            total++; if (bus_o !== e) begin bad++; $display("FAIL wrap%0d got=%h want=%h", i, bus_o, e); end
            total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready%0d got=%b want=1", i, tx_ready); end
        end
        tick();
        total++; if (bus_o !== '0) begin bad++; $display("FAIL wrap_idle got=%h want=%h", bus_o, 11'h0); end
    endtask

    task automatic test_reset_mid();
        tx_valid = 1'b1; tx_addr = 2'd2; tx_data = 8'hE1; bus_i = pkt(2'd0, 8'h91);
        tick();
        tx_data = 8'hE2; bus_i = pkt(2'd3, 8'h92);
        tick();
        tx_valid = 1'b0; bus_i = pkt(2'd1, 8'h93);
        tick();
        bus_i = '0;
        total++; if (bus_o !== pkt(2'd2, 8'hE1)) begin bad++; $display("FAIL rmid_pre got=%h want=%h", bus_o, pkt(2'd2, 8'hE1)); end
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_rx got=%b want=1", rx_valid); end
        reset = 1'b1;
        #2;
        total++; if (bus_o !== '0) begin bad++; $display("FAIL rmid_bus_o got=%h want=%h", bus_o, 11'h0); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rmid_rx_valid got=%b want=0", rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rmid_rx_data got=%h want=00", rx_data); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rmid_tx_ready got=%b want=1", tx_ready); end
`ifdef PI_LEAF_STATS_EN
        total++; if (bounce_cnt !== 16'd0) begin bad++; $display("FAIL rmid_bounce_cnt got=%0d want=0", bounce_cnt); end
`endif
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (bus_o !== '0) begin bad++; $display("FAIL rmid_stale%0d got=%h want=%h", i, bus_o, 11'h0); end
            total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rmid_rx_stale%0d got=%b want=0", i, rx_valid); end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        bus_i    = '0;
        tx_valid = 1'b0;
        tx_addr  = '0;
        tx_data  = '0;
        rx_ready = 1'b0;
        #2;
        test_reset();
        test_basic_tx();
        test_basic_rx();
        test_rx_full_bounce();
        test_misroute_contention();
        test_tx_full();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
